// File: rtl/seq_alu_md.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_md
// Purpose  : Handshaked, registered N-bit ALU. It executes one operation at a
//            time. AND/OR/ADD/SUB/SLT/NOR finish in one cycle. Unsigned
//            multiply (shift-add) and unsigned divide (restoring) take N
//            iterations.
// Ports    : clk, rst_n (sync, active-low)
//            in_valid/in_ready  : operand handshake (a, b, op)
//            out_valid/out_ready: result handshake
//            result, result_hi  : low word / quotient, high word / remainder
//            cout, zero, overflow: status flags for the held result
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu_md #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         cout,
    output logic         zero,
    output logic         overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_SUB  = 3'b011;
    localparam logic [2:0] c_OP_SLT  = 3'b100;
    localparam logic [2:0] c_OP_NOR  = 3'b101;
    localparam logic [2:0] c_OP_MULU = 3'b110;
    localparam logic [2:0] c_OP_DIVU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          mul_q;      // 1: MULU in progress, 0: DIVU in progress
    logic [N-1:0]  b_q;        // multiplicand / divisor
    logic [N-1:0]  hi_q;       // partial product high / partial remainder
    logic [N-1:0]  lo_q;       // multiplier being shifted out / quotient
    logic          out_valid_q;
    logic [N-1:0]  result_q;
    logic [N-1:0]  result_hi_q;
    logic          cout_q;
    logic          zero_q;
    logic          overflow_q;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs at the accept edge
    // ------------------------------------------------------------------
    logic         w_sub;
    logic [N-1:0] w_bx;
    logic [N:0]   w_sum;
    logic         w_add_ovf;

    always_comb begin
        // SLT reuses the subtractor: a < b is sign(a-b) corrected by overflow
        w_sub     = (op == c_OP_SUB) || (op == c_OP_SLT);
        w_bx      = w_sub ? ~b : b;
        w_sum     = {1'b0, a} + {1'b0, w_bx} + {{N{1'b0}}, w_sub};
        // carry into MSB is recovered from the MSB sum bit
        w_add_ovf = (a[N-1] ^ w_bx[N-1] ^ w_sum[N-1]) ^ w_sum[N];
    end

    logic [N-1:0] res_d;
    logic         cout_d;
    logic         ovf_d;

    always_comb begin
        res_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        case (op)
            c_OP_AND: res_d = a & b;
            c_OP_OR:  res_d = a | b;
            c_OP_ADD,
            c_OP_SUB: begin
                res_d  = w_sum[N-1:0];
                cout_d = w_sum[N];
                ovf_d  = w_add_ovf;
            end
            c_OP_SLT: res_d = {{(N-1){1'b0}}, w_sum[N-1] ^ w_add_ovf};
            c_OP_NOR: res_d = ~(a | b);
            default:  res_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration of multiply or divide
    // ------------------------------------------------------------------
    logic [N:0]   w_madd;
    logic [N:0]   w_shift;
    logic [N-1:0] w_diff;
    logic         w_ge;
    logic [N-1:0] hi_d;
    logic [N-1:0] lo_d;

    always_comb begin
        // shift-add: add b when the current multiplier LSB is set, then
        // shift the whole {carry, hi, lo} right by one
        w_madd  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // restoring divide: bring down the next dividend bit (MSB first)
        w_shift = {hi_q, lo_q[N-1]};
        w_ge    = (w_shift >= {1'b0, b_q});
        // when w_ge holds the difference is below 2^N, so N bits suffice
        w_diff  = w_shift[N-1:0] - b_q;
        if (mul_q) begin
            hi_d = w_madd[N:1];
            lo_d = {w_madd[0], lo_q[N-1:1]};
        end else begin
            hi_d = w_ge ? w_diff : w_shift[N-1:0];
            lo_d = {lo_q[N-2:0], w_ge};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mul_q       <= 1'b0;
            b_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        b_q <= b;
                        if (op == c_OP_MULU || op == c_OP_DIVU) begin
                            mul_q   <= (op == c_OP_MULU);
                            hi_q    <= '0;
                            lo_q    <= a;
                            cnt_q   <= CW'(N - 1);
                            state_q <= ST_CALC;
                        end else begin
                            result_q    <= res_d;
                            result_hi_q <= '0;
                            cout_q      <= cout_d;
                            zero_q      <= (res_d == '0);
                            overflow_q  <= ovf_d;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        result_q    <= lo_d;
                        result_hi_q <= hi_d;
                        cout_q      <= 1'b0;
                        zero_q      <= (lo_d == '0);
                        // MULU: product does not fit in N bits; DIVU: b == 0
                        overflow_q  <= mul_q ? (hi_d != '0) : (b_q == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && rst_n;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu_md
// Purpose  : Self-checking bench for seq_alu_md (N=8). Table-driven vectors
//            go through a scoreboard queue. Hand-written sequences cover
//            backpressure and reset during an iterative operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu_md;

    localparam int N = 8;

    localparam logic [2:0] c_AND  = 3'b000;
    localparam logic [2:0] c_OR   = 3'b001;
    localparam logic [2:0] c_ADD  = 3'b010;
    localparam logic [2:0] c_SUB  = 3'b011;
    localparam logic [2:0] c_SLT  = 3'b100;
    localparam logic [2:0] c_NOR  = 3'b101;
    localparam logic [2:0] c_MULU = 3'b110;
    localparam logic [2:0] c_DIVU = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic [N-1:0] result_hi;
    logic         cout;
    logic         zero;
    logic         overflow;

    seq_alu_md #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .cout      (cout),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [7:0] hi;
        logic       c;
        logic       z;
        logic       v;
        int         lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [2:0] o, input logic [7:0] a_i,
                                input logic [7:0] b_i, input logic [7:0] r, input logic [7:0] h,
                                input logic c, input logic z, input logic v);
        vec_t t;
        t.name = n; t.op = o; t.a = a_i; t.b = b_i;
        t.res = r; t.hi = h; t.c = c; t.z = z; t.v = v;
        t.lat = (o == c_MULU || o == c_DIVU) ? N + 1 : 1;
        return t;
    endfunction

    // Drive one operation, push its expectation, then wait for and check it.
    task automatic run_vec(input vec_t v);
        int   lat;
        int   guard;
        logic rdy_seen;
        vec_t e;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({v.name, "_ready_wait"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
        sb.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 4 * N) begin
            if (in_ready) rdy_seen = 1'b1;
            // junk on the inputs while busy must be ignored
            in_valid = 1'($urandom_range(0, 1));
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({v.name, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({v.name, "_latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, "_ready_busy"}, 32'(rdy_seen), 32'd0);
        chk({v.name, "_ready_done"}, 32'(in_ready), 32'd0);
        if (sb.size() == 0) begin
            chk({v.name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.name, "_result"},    32'(result),    32'(e.res));
            chk({e.name, "_result_hi"}, 32'(result_hi), 32'(e.hi));
            chk({e.name, "_cout"},      32'(cout),      32'(e.c));
            chk({e.name, "_zero"},      32'(zero),      32'(e.z));
            chk({e.name, "_overflow"},  32'(overflow),  32'(e.v));
        end
        @(posedge clk); #1;
        chk({v.name, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({v.name, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ovs;

        //             name          op      a      b      res    hi     c  z  v
        vecs.push_back(mk("add_ovf",  c_ADD,  8'h7F, 8'h01, 8'h80, 8'h00, 0, 0, 1));
        vecs.push_back(mk("add_wrap", c_ADD,  8'hFF, 8'h01, 8'h00, 8'h00, 1, 1, 0));
        vecs.push_back(mk("sub_eq",   c_SUB,  8'h05, 8'h05, 8'h00, 8'h00, 1, 1, 0));
        vecs.push_back(mk("sub_brw",  c_SUB,  8'h00, 8'h01, 8'hFF, 8'h00, 0, 0, 0));
        vecs.push_back(mk("sub_ovf",  c_SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 1, 0, 1));
        vecs.push_back(mk("slt_neg",  c_SLT,  8'hFF, 8'h01, 8'h01, 8'h00, 0, 0, 0));
        vecs.push_back(mk("slt_pos",  c_SLT,  8'h01, 8'hFF, 8'h00, 8'h00, 0, 1, 0));
        vecs.push_back(mk("slt_ovf",  c_SLT,  8'h80, 8'h7F, 8'h01, 8'h00, 0, 0, 0));
        vecs.push_back(mk("and",      c_AND,  8'hF0, 8'h3C, 8'h30, 8'h00, 0, 0, 0));
        vecs.push_back(mk("or",       c_OR,   8'hF0, 8'h0F, 8'hFF, 8'h00, 0, 0, 0));
        vecs.push_back(mk("nor_z",    c_NOR,  8'h00, 8'h00, 8'hFF, 8'h00, 0, 0, 0));
        vecs.push_back(mk("nor_o",    c_NOR,  8'hFF, 8'h00, 8'h00, 8'h00, 0, 1, 0));
        vecs.push_back(mk("mul_max",  c_MULU, 8'hFF, 8'hFF, 8'h01, 8'hFE, 0, 0, 1));
        vecs.push_back(mk("mul_sml",  c_MULU, 8'h0C, 8'h0B, 8'h84, 8'h00, 0, 0, 0));
        vecs.push_back(mk("mul_zero", c_MULU, 8'h00, 8'h55, 8'h00, 8'h00, 0, 1, 0));
        vecs.push_back(mk("mul_256",  c_MULU, 8'h10, 8'h10, 8'h00, 8'h01, 0, 1, 1));
        vecs.push_back(mk("div_100_7",c_DIVU, 8'd100,8'd7,  8'd14, 8'd2,  0, 0, 0));
        vecs.push_back(mk("div_by0",  c_DIVU, 8'h2A, 8'h00, 8'hFF, 8'h2A, 0, 0, 1));
        vecs.push_back(mk("div_small",c_DIVU, 8'h03, 8'h05, 8'h00, 8'h03, 0, 1, 0));
        vecs.push_back(mk("div_by1",  c_DIVU, 8'hFF, 8'h01, 8'hFF, 8'h00, 0, 0, 0));

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result",    32'(result),    32'd0);
        chk("rst_result_hi", 32'(result_hi), 32'd0);
        chk("rst_flags",     32'({cout, zero, overflow}), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // backpressure: result held while out_ready=0 and inputs wiggle
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; op = c_ADD; a = 8'h12; b = 8'h34;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
            @(posedge clk); #1;
            chk("bp_valid",    32'(out_valid), 32'd1);
            chk("bp_result",   32'(result),    32'h46);
            chk("bp_result_hi",32'(result_hi), 32'h00);
            chk("bp_flags",    32'({cout, zero, overflow}), 32'd0);
            chk("bp_in_ready", 32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);
        chk("bp_result_kept",   32'(result),    32'h46);
        @(posedge clk); #1;
        chk("bp_no_accept", 32'(out_valid), 32'd0);

        // reset during the third CALC cycle of a multiply
        @(negedge clk);
        in_valid = 1'b1; op = c_MULU; a = 8'hAB; b = 8'hCD;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        chk("abort_ready_in_rst", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("abort_valid",     32'(out_valid), 32'd0);
        chk("abort_result",    32'(result),    32'd0);
        chk("abort_result_hi", 32'(result_hi), 32'd0);
        chk("abort_flags",     32'({cout, zero, overflow}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ovs = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid) ovs = 1'b1;
        end
        chk("abort_no_valid", 32'(ovs), 32'd0);
        chk("abort_ready",    32'(in_ready), 32'd1);
        run_vec(mk("add_after_rst", c_ADD, 8'h03, 8'h04, 8'h07, 8'h00, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
